fuzz_vector_sequencer: RTL

//  Sequences stimulus into a synthesized fuzz DUT (`top`) and collects its responses.
//  - Pulls packed input vectors {wire0..wire4} from a valid/ready stream and drives them onto the DUT input bus.
//  - Waits a programmable settle time, then captures the DUT output bus y and emits it on a valid/ready response stream.
//  - Replaces open-loop #10 stimulus with clocked, back-pressurable scheduling for simulator and hardware harnesses.

---
 rtl/fuzz_vector_sequencer_if.sv | 30 +++
 rtl/fuzz_vector_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fuzz_vector_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fuzz_vector_sequencer_if : stimulus, response and DUT-bus signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface fuzz_vector_sequencer_if #(
   parameter int IN_W  = 63,
   parameter int OUT_W = 550
);
   logic             vec_valid;
   logic [IN_W-1:0]  vec_data;
   logic             vec_ready;
   logic [IN_W-1:0]  dut_in;
   logic [OUT_W-1:0] dut_out;
   logic             rsp_valid;
   logic [OUT_W-1:0] rsp_data;
   logic [15:0]      rsp_idx;
   logic             rsp_ready;

   // master = sequencer side, slave = harness / fuzz DUT side
   modport master (
      input  vec_valid, vec_data, dut_out, rsp_ready,
      output vec_ready, dut_in, rsp_valid, rsp_data, rsp_idx
   );
   modport slave (
      output vec_valid, vec_data, dut_out, rsp_ready,
      input  vec_ready, dut_in, rsp_valid, rsp_data, rsp_idx
   );
endinterface
`default_nettype wire

// File: rtl/fuzz_vector_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fuzz_vector_sequencer : clocked stimulus/response scheduler for a fuzz DUT.
// Optional running response signature enabled by macro SEQ_SIGNATURE_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module fuzz_vector_sequencer #(
   parameter int IN_W       = 63,
   parameter int OUT_W      = 550,
   parameter int SETTLE_CYC = 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        start,
   input  wire logic [15:0] num_vec,
   input  wire logic        abort,
   fuzz_vector_sequencer_if.master bus,
   output logic             busy,
   output logic             done,
   output logic [31:0]      sig
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_SETTLE = 2'd2,
      S_EMIT   = 2'd3
   } state_t;

   localparam logic [7:0] c_CNT_INIT = 8'(SETTLE_CYC - 1);

   state_t           r_state;
   logic [7:0]       r_cnt;
   logic [15:0]      r_num;
   logic [15:0]      r_idx;
   logic             r_vec_ready;
   logic [IN_W-1:0]  r_dut_in;
   logic             r_rsp_valid;
   logic [OUT_W-1:0] r_rsp_data;
   logic [15:0]      r_rsp_idx;
   logic             r_busy;
   logic             r_done;

   logic w_start_acc;
   logic w_capture;

   assign w_start_acc = (r_state == S_IDLE) && start;
   assign w_capture   = (r_state == S_SETTLE) && (r_cnt == 8'd0) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_num       <= 16'd0;
         r_idx       <= 16'd0;
         r_vec_ready <= 1'b0;
         r_dut_in    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_idx   <= 16'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // abort wins over every handshake in the same cycle
         if (abort && (r_state != S_IDLE)) begin
            r_state     <= S_IDLE;
            r_dut_in    <= '0;
            r_rsp_valid <= 1'b0;
            r_vec_ready <= 1'b0;
            r_busy      <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     if (num_vec == 16'd0) begin
                        r_done <= 1'b1;
                     end else begin
                        r_num       <= num_vec;
                        r_idx       <= 16'd0;
                        r_busy      <= 1'b1;
                        r_vec_ready <= 1'b1;
                        r_state     <= S_FETCH;
                     end
                  end
               end
               S_FETCH: begin
                  if (bus.vec_valid && r_vec_ready) begin
                     r_dut_in    <= bus.vec_data;
                     r_vec_ready <= 1'b0;
                     r_cnt       <= c_CNT_INIT;
                     r_state     <= S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (r_cnt == 8'd0) begin
                     r_rsp_data  <= bus.dut_out;
                     r_rsp_idx   <= r_idx;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_EMIT;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
               S_EMIT: begin
                  if (bus.rsp_ready) begin
                     r_rsp_valid <= 1'b0;
                     r_idx       <= r_idx + 16'd1;
                     if (r_idx + 16'd1 == r_num) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state     <= S_FETCH;
                        r_vec_ready <= 1'b1;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef SEQ_SIGNATURE_EN
   localparam int c_SLICES = (OUT_W + 31) / 32;

   logic [c_SLICES*32-1:0] w_pad;
   logic [31:0]            w_fold;
   logic [31:0]            r_sig;

   always_comb begin
      w_pad             = '0;
      w_pad[OUT_W-1:0]  = bus.dut_out;
      w_fold            = 32'd0;
      for (int i = 0; i < c_SLICES; i++) begin
         w_fold = w_fold ^ w_pad[i*32 +: 32];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= 32'd0;
      end else if (w_start_acc) begin
         r_sig <= 32'd0;
      end else if (w_capture) begin
         r_sig <= {r_sig[30:0], r_sig[31]} ^ w_fold;
      end
   end

   assign sig = r_sig;
`else
   assign sig = 32'd0;
`endif

   assign bus.vec_ready = r_vec_ready;
   assign bus.dut_in    = r_dut_in;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_idx   = r_rsp_idx;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule
`default_nettype wire
